// File: rtl/whirlpool_theta_iter.sv
`default_nettype none
// ============================================================================
// Module      : whirlpool_theta_iter
// Description : Iterative Whirlpool theta (MixRows) over a 512-bit state,
//               ROWS_PER_CYCLE rows per clock, valid/ready on both sides.
//               Define WHIRLPOOL_THETA_KEYADD_EN to fold key addition (sigma)
//               into the same pass via an extra round_key port.
// Revision    : 1.0 - initial release
// ============================================================================
module whirlpool_theta_iter #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef WHIRLPOOL_THETA_KEYADD_EN
    input  logic [511:0] round_key,
`endif
    output logic [511:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int C_STEPS = 8 / ROWS_PER_CYCLE;
    localparam int CW      = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(C_STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 ||
              ROWS_PER_CYCLE == 4 || ROWS_PER_CYCLE == 8)) begin : g_bad_rows
            $error("whirlpool_theta_iter: ROWS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    // GF(2^8) doubling, reduction polynomial x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'd1:    return a;
            4'd2:    return x2;
            4'd4:    return x4;
            4'd5:    return x4 ^ a;
            4'd8:    return x8;
            4'd9:    return x8 ^ a;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] coef(input int idx);
        case (idx)
            0:       return 4'd1;
            1:       return 4'd9;
            2:       return 4'd2;
            3:       return 4'd5;
            4:       return 4'd8;
            5:       return 4'd1;
            6:       return 4'd4;
            default: return 4'd1;
        endcase
    endfunction

    // Circulant row product: B[j] = XOR_k A[k] * C[(k-j) mod 8]
    function automatic logic [63:0] theta_row(input logic [63:0] a);
        logic [63:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) begin
                b[63-8*j -: 8] = b[63-8*j -: 8] ^ gf_mul(a[63-8*k -: 8], coef((k - j) & 7));
            end
        end
        return b;
    endfunction

    logic [1:0]    r_fsm;
    logic [CW-1:0] r_cnt;
    logic [511:0]  r_data;
`ifdef WHIRLPOOL_THETA_KEYADD_EN
    logic [511:0]  r_key;
`endif

    logic [1:0]    w_next_fsm;
    logic          w_load;
    logic [511:0]  w_next_data;
    logic [63:0]   w_row;
    int            w_base;

    always_comb begin
        w_next_data = r_data;
        w_row       = '0;
        w_base      = int'(r_cnt) * ROWS_PER_CYCLE;
        for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
            w_row = theta_row(r_data[511-64*(w_base+i) -: 64]);
`ifdef WHIRLPOOL_THETA_KEYADD_EN
            w_row = w_row ^ r_key[511-64*(w_base+i) -: 64];
`endif
            w_next_data[511-64*(w_base+i) -: 64] = w_row;
        end
    end

    always_comb begin
        w_next_fsm = r_fsm;
        w_load     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load     = 1'b1;
                    w_next_fsm = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_next_fsm = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // Accepting the next state on the handshake edge avoids a bubble
                if (out_ready) begin
                    if (in_valid) begin
                        w_load     = 1'b1;
                        w_next_fsm = S_BUSY;
                    end else begin
                        w_next_fsm = S_IDLE;
                    end
                end
            end
            default: w_next_fsm = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm  <= S_IDLE;
            r_cnt  <= '0;
            r_data <= '0;
`ifdef WHIRLPOOL_THETA_KEYADD_EN
            r_key  <= '0;
`endif
        end else begin
            r_fsm <= w_next_fsm;
            if (w_load) begin
                r_data <= in_data;
                r_cnt  <= '0;
`ifdef WHIRLPOOL_THETA_KEYADD_EN
                r_key  <= round_key;
`endif
            end else if (r_fsm == S_BUSY) begin
                r_data <= w_next_data;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign out_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_whirlpool_theta_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_whirlpool_theta_iter
// Description : Directed bench driving four instances (R = 1, 2, 4, 8) in
//               parallel; backpressure and reset scenarios target R = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_whirlpool_theta_iter;

    logic         clk;
    logic         rst;
    logic [511:0] in_data;
    logic         in_valid;
    logic         out_ready;
`ifdef WHIRLPOOL_THETA_KEYADD_EN
    logic [511:0] round_key;
`endif

    logic [511:0] od [4];
    logic         ov [4];
    logic         ir [4];
    logic         bz [4];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [511:0] V_ZERO  = '0;
    localparam logic [511:0] V_E00   = {8'h01, 504'h0};
    localparam logic [511:0] X_E00   = {64'h0101040108050209, 448'h0};
    localparam logic [511:0] V_R3    = {192'h0, 8'h80, 312'h0};
    localparam logic [511:0] X_R3    = {192'h0, 64'h80803A8074BA1DF4, 256'h0};
    localparam logic [511:0] V_ONES  = {64{8'h01}};
    localparam logic [511:0] X_ONES  = {64{8'h03}};
    localparam logic [511:0] V_R5    = {336'h0, 8'h02, 168'h0};
    localparam logic [511:0] X_R5    = {320'h0, 64'h041202020802100A, 128'h0};

    int c_lat [4] = '{9, 5, 3, 2};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            whirlpool_theta_iter #(.ROWS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_data   (in_data),
                .in_valid  (in_valid),
                .in_ready  (ir[g]),
`ifdef WHIRLPOOL_THETA_KEYADD_EN
                .round_key (round_key),
`endif
                .out_data  (od[g]),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .busy      (bz[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latency counts the acceptance cycle as cycle 1
    task automatic transact(input string tag, input logic [511:0] d, input logic [511:0] exp);
        int           lat [4];
        logic [511:0] res [4];
        int           cyc;
        for (int i = 0; i < 4; i++) begin
            lat[i] = 0;
            res[i] = '0;
        end
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 20 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0 || lat[3] == 0)) begin
            step();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && lat[i] == 0) begin
                    lat[i] = cyc;
                    res[i] = od[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lat_r%0d", tag, 1 << i), 512'(lat[i]), 512'(c_lat[i]));
            check($sformatf("%s_data_r%0d", tag, 1 << i), res[i], exp);
        end
        step();
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef WHIRLPOOL_THETA_KEYADD_EN
        round_key = '0;
`endif
        step();
        step();
        check("rst_data", od[0], V_ZERO);
        check("rst_ovalid", 512'(ov[0]), 512'(0));
        check("rst_busy", 512'(bz[0]), 512'(0));
        check("rst_inready", 512'(ir[0]), 512'(1));
        rst = 1'b0;
        step();

        transact("zero", V_ZERO, V_ZERO);
        transact("e00", V_E00, X_E00);
        transact("r3", V_R3, X_R3);
        transact("ones", V_ONES, X_ONES);

        // Backpressure: result must hold while the sink stalls
        out_ready = 1'b0;
        in_data   = V_E00;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_data   = V_ONES;
        cyc = 1;
        while (!ov[0] && cyc < 20) begin
            step();
            cyc++;
        end
        check("bp_lat", 512'(cyc), 512'(9));
        in_valid = 1'b1;
        repeat (5) begin
            check("bp_hold", od[0], X_E00);
            check("bp_inready", 512'(ir[0]), 512'(0));
            check("bp_ovalid", 512'(ov[0]), 512'(1));
            step();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_inready", 512'(ir[0]), 512'(1));
        step();
        in_valid = 1'b0;
        check("b2b_busy", 512'(bz[0]), 512'(1));
        check("b2b_ovalid", 512'(ov[0]), 512'(0));
        cyc = 1;
        while (!ov[0] && cyc < 20) begin
            step();
            cyc++;
        end
        check("b2b_lat", 512'(cyc), 512'(9));
        check("b2b_data", od[0], X_ONES);
        repeat (3) step();

        // Abort in the fourth busy cycle
        in_data  = V_R3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("mid_busy", 512'(bz[0]), 512'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_ovalid", 512'(ov[0]), 512'(0));
        check("mid_busy0", 512'(bz[0]), 512'(0));
        check("mid_inready", 512'(ir[0]), 512'(1));
        check("mid_data", od[0], V_ZERO);
        transact("fresh", V_R5, X_R5);

`ifdef WHIRLPOOL_THETA_KEYADD_EN
        round_key = {64{8'hFF}};
        transact("key0", V_ZERO, {64{8'hFF}});
        transact("key1", V_E00, {64'hFEFEFBFEF7FAFDF6, {448{1'b1}}});
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/whirlpool_theta_iter.md
Name: whirlpool_theta_iter

Overview:
- Sequential, parametrised successor to the combinational Whirlpool W-cipher theta (MixRows) layer.
- Accepts a full 512-bit 8x8 byte state over a valid/ready handshake and applies theta in place, ROWS_PER_CYCLE rows per clock, with one shared bank of row multipliers.
- Returns the result over a valid/ready handshake.
- Sits between the gamma/pi stages and key addition in area-reduced W-cipher round datapaths.

Parameters:
- ROWS_PER_CYCLE, 1: rows transformed per busy cycle. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  512  state; row r at [511-64r -: 64]; byte c of row r at [511-64r-8c -: 8]
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a state
- out_data  output  512  theta(state), same byte layout as in_data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- busy  output  1  high while rows are being transformed

Behaviour:
- Arithmetic:
  - GF(2^8) with reduction polynomial x^8+x^4+x^3+x^2+1 (xtime XOR 0x1D when the shifted-out MSB is 1).
  - Per row: B[j] = XOR over k of A[k]*C[(k-j) mod 8], with C = {01,09,02,05,08,01,04,01}.
  - Rows are independent.
  - Multiplies by 4, 5, 8 and 9 are built from chained xtime plus XOR; no lookup tables.
- Storage and counter:
  - One 512-bit state register feeds out_data directly.
  - Row counter width is clog2(8/ROWS_PER_CYCLE), minimum 1 bit.
- States:
  - IDLE:
    - in_ready=1, out_valid=0, busy=0.
    - On in_valid&in_ready: load the register, clear the counter, go to BUSY.
  - BUSY:
    - busy=1, in_ready=0, out_valid=0.
    - Each cycle replace rows cnt*R .. cnt*R+R-1 with their theta image (R = ROWS_PER_CYCLE), then increment the counter.
    - After the cycle that processes rows 8-R..7, go to DONE.
  - DONE:
    - out_valid=1, busy=0, and out_data is stable until accepted.
    - in_ready = out_ready.
    - out_valid&out_ready with in_valid: load the new state and go to BUSY. There is no bubble.
    - out_valid&out_ready without in_valid: go to IDLE.
    - Without out_ready: stay in DONE. in_data is ignored.
- Latency: acceptance edge to out_valid high is 8/R+1 cycles.
  - R=1: 9 cycles.
  - R=8: 2 cycles.
- Throughput: one state per 8/R+1 cycles under continuous valid and ready.
- Reset:
  - rst=1 at any edge forces IDLE, clears the state register and counter, and aborts any operation in progress.
  - Reset values: out_data=0, out_valid=0, busy=0, in_ready=1 in the cycle after reset.
  - rst overrides any simultaneous handshake.
- in_valid while in BUSY is ignored, because in_ready=0. The producer holds in_data until it is accepted.

Optional Feature:
- Macro WHIRLPOOL_THETA_KEYADD_EN.
- When defined:
  - Adds input port round_key [511:0], sampled together with in_data on acceptance into a 512-bit key register.
  - Each row is XORed with the matching key row (sigma) in the same cycle it is transformed, so out_data = theta(state) XOR key.
  - Latency is unchanged.
  - The key register also clears on rst.
- When undefined:
  - The port and the key register are absent.
  - out_data = theta(state).

Test Plan:
- All-zero state, R=1 -> out_valid rises 9 cycles after acceptance; out_data = 0.
- Byte (0,0)=0x01, rest 0 -> row 0 = 01 01 04 01 08 05 02 09, rows 1-7 = 0; identical result for R=1, 2, 4 and 8, with latencies 9, 5, 3 and 2.
- Byte (3,0)=0x80, rest 0 -> row 3 = 80 80 3A 80 74 BA 1D F4 (exercises reduction), other rows 0.
- Every byte 0x01 -> every output byte 0x03.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable and in_ready=0.
  - Then out_ready=1 with in_valid=1 -> the next state is accepted in the same cycle and the next out_valid follows 8/R+1 cycles later.
- Reset mid-operation: assert rst in the 4th BUSY cycle (R=1) -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0; a fresh state then completes normally.
- With WHIRLPOOL_THETA_KEYADD_EN defined:
  - Zero state, key of all 0xFF -> out_data is all 0xFF.
  - Byte (0,0)=0x01 with the same key -> row 0 = FE FE FB FE F7 FA FD F6.
